mem_byte_mux: RTL and testbench

Byte-lane steering block for the data memory path. It takes the buffered 32-bit word read from block RAM, the byte offset of the access and the access-size/sign mask. It produces two results, both registered: the load result (extracted and zero- or sign-extended) and the store replacement word (the new bytes merged into the old word). It sits between the data-memory word buffer and the read-data / RAM-write paths.

---
 rtl/mem_byte_mux.sv | 105 ++++++++++
 tb/tb_mem_byte_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_byte_mux.sv
// rtl/mem_byte_mux.sv - registered byte-lane steering for data memory loads and stores (MEMMUX_MISALIGN_EN adds misaligned flag)
module mem_byte_mux (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] word_buf,
    input  logic [31:0] write_data_buffer,
    input  logic [3:0]  sign_mask_buf,
    output logic [31:0] read_buf,
`ifdef MEMMUX_MISALIGN_EN
    output logic        misaligned,
`endif
    output logic [31:0] replacement_word
);

    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;

    logic        is_byte;
    logic        is_half;
    logic        sign_en;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_next;
    logic [31:0] store_next;

    // Unrecognised size codes fall through to word behaviour.
    always_comb begin
        is_byte = (sign_mask_buf[2:0] == SIZE_BYTE);
        is_half = (sign_mask_buf[2:0] == SIZE_HALF);
        sign_en = sign_mask_buf[3];
    end

    always_comb begin
        sel_byte = word_buf[7:0];
        case (addr_lsb)
            2'd0: sel_byte = word_buf[7:0];
            2'd1: sel_byte = word_buf[15:8];
            2'd2: sel_byte = word_buf[23:16];
            2'd3: sel_byte = word_buf[31:24];
            default: sel_byte = word_buf[7:0];
        endcase
        sel_half = addr_lsb[1] ? word_buf[31:16] : word_buf[15:0];
    end

    always_comb begin
        load_next = word_buf;
        if (is_byte) begin
            load_next = {{24{sign_en & sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_next = {{16{sign_en & sel_half[15]}}, sel_half};
        end
    end

    // Unselected lanes pass through word_buf untouched.
    always_comb begin
        store_next = write_data_buffer;
        if (is_byte) begin
            store_next = word_buf;
            case (addr_lsb)
                2'd0: store_next[7:0]   = write_data_buffer[7:0];
                2'd1: store_next[15:8]  = write_data_buffer[7:0];
                2'd2: store_next[23:16] = write_data_buffer[7:0];
                2'd3: store_next[31:24] = write_data_buffer[7:0];
                default: store_next = word_buf;
            endcase
        end else if (is_half) begin
            store_next = word_buf;
            if (addr_lsb[1]) begin
                store_next[31:16] = write_data_buffer[15:0];
            end else begin
                store_next[15:0] = write_data_buffer[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_buf         <= 32'h0;
            replacement_word <= 32'h0;
        end else begin
            read_buf         <= load_next;
            replacement_word <= store_next;
        end
    end

`ifdef MEMMUX_MISALIGN_EN
    logic misaligned_next;

    always_comb begin
        misaligned_next = (is_half & addr_lsb[0]) |
                          ((sign_mask_buf[2:0] == SIZE_WORD) & (addr_lsb != 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= misaligned_next;
        end
    end
`endif

endmodule

// File: tb/tb_mem_byte_mux.sv
// tb/tb_mem_byte_mux.sv - directed self-checking bench for mem_byte_mux
module tb_mem_byte_mux;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr_lsb;
    logic [31:0] word_buf;
    logic [31:0] write_data_buffer;
    logic [3:0]  sign_mask_buf;
    logic [31:0] read_buf;
    logic [31:0] replacement_word;
`ifdef MEMMUX_MISALIGN_EN
    logic        misaligned;
`endif

    int vectors;
    int miscompares;

    mem_byte_mux dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .addr_lsb          (addr_lsb),
        .word_buf          (word_buf),
        .write_data_buffer (write_data_buffer),
        .sign_mask_buf     (sign_mask_buf),
        .read_buf          (read_buf),
`ifdef MEMMUX_MISALIGN_EN
        .misaligned        (misaligned),
`endif
        .replacement_word  (replacement_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] wb, input logic [31:0] wd,
                         input logic [3:0] mask, input logic [1:0] al);
        word_buf          = wb;
        write_data_buffer = wd;
        sign_mask_buf     = mask;
        addr_lsb          = al;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n             = 1'b0;
        word_buf          = 32'hA5A5_5A5A;
        write_data_buffer = 32'h1234_5678;
        sign_mask_buf     = 4'b1001;
        addr_lsb          = 2'd3;

        repeat (3) @(posedge clk);
        #1;
        check("reset_read", read_buf, 32'h0);
        check("reset_repl", replacement_word, 32'h0);
`ifdef MEMMUX_MISALIGN_EN
        check("reset_mis", {31'h0, misaligned}, 32'h0);
`endif

        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h80C3_7F01, 32'h0000_0000, 4'b1001, 2'd2);
        check("byte_load_sext", read_buf, 32'hFFFF_FFC3);
        check("byte_load_repl", replacement_word, 32'h8000_7F01);

        apply(32'h80C3_7F01, 32'h0000_0000, 4'b0001, 2'd2);
        check("byte_load_zext", read_buf, 32'h0000_00C3);

        apply(32'h80C3_7F01, 32'h0000_0000, 4'b1001, 2'd3);
        check("byte_load_lane3", read_buf, 32'hFFFF_FF80);

        apply(32'h80C3_7F01, 32'h0000_0000, 4'b1001, 2'd0);
        check("byte_load_lane0", read_buf, 32'h0000_0001);

        apply(32'h8001_1234, 32'h0000_0000, 4'b1011, 2'd2);
        check("half_load_hi", read_buf, 32'hFFFF_8001);

        apply(32'h8001_1234, 32'h0000_0000, 4'b1011, 2'd0);
        check("half_load_lo", read_buf, 32'h0000_1234);
`ifdef MEMMUX_MISALIGN_EN
        check("half_aligned_mis", {31'h0, misaligned}, 32'h0);
`endif

        apply(32'h8001_1234, 32'h0000_0000, 4'b1011, 2'd3);
        check("half_load_odd", read_buf, 32'hFFFF_8001);
`ifdef MEMMUX_MISALIGN_EN
        check("half_odd_mis", {31'h0, misaligned}, 32'h1);
`endif

        apply(32'h1122_3344, 32'hDEAD_BEEF, 4'b0001, 2'd1);
        check("byte_store_repl", replacement_word, 32'h1122_EF44);
        check("byte_store_read", read_buf, 32'h0000_0033);

        apply(32'h1122_3344, 32'hDEAD_BEEF, 4'b0011, 2'd2);
        check("half_store_repl", replacement_word, 32'hBEEF_3344);
        check("half_store_read", read_buf, 32'h0000_1122);

        apply(32'h1122_3344, 32'hDEAD_BEEF, 4'b0011, 2'd0);
        check("half_store_lo", replacement_word, 32'h1122_BEEF);

        apply(32'h1122_3344, 32'hDEAD_BEEF, 4'b0111, 2'd0);
        check("word_store_repl", replacement_word, 32'hDEAD_BEEF);
        check("word_store_read", read_buf, 32'h1122_3344);
`ifdef MEMMUX_MISALIGN_EN
        check("word_aligned_mis", {31'h0, misaligned}, 32'h0);
`endif

        apply(32'h8122_3344, 32'hDEAD_BEEF, 4'b1111, 2'd1);
        check("word_ignores_offset", read_buf, 32'h8122_3344);
`ifdef MEMMUX_MISALIGN_EN
        check("word_misaligned", {31'h0, misaligned}, 32'h1);
`endif

        apply(32'h8122_3344, 32'hCAFE_F00D, 4'b1000, 2'd2);
        check("other_code_read", read_buf, 32'h8122_3344);
        check("other_code_repl", replacement_word, 32'hCAFE_F00D);

        word_buf          = 32'h0000_0000;
        write_data_buffer = 32'hFFFF_FFFF;
        sign_mask_buf     = 4'b1001;
        addr_lsb          = 2'd0;
        #2;
        check("hold_read", read_buf, 32'h8122_3344);
        check("hold_repl", replacement_word, 32'hCAFE_F00D);

        apply(32'h1122_3344, 32'hDEAD_BEEF, 4'b0111, 2'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_read", read_buf, 32'h0);
        check("async_reset_repl", replacement_word, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h80C3_7F01, 32'h0000_0000, 4'b0001, 2'd2);
        check("post_reset_read", read_buf, 32'h0000_00C3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
